bcd_to_binary: RTL and testbench

Sequential converter that turns the six-digit BCD reaction time produced by the count-timer chain into a plain binary millisecond count. It implements reverse double-dabble: one right shift plus a per-digit correction per clock. It sits between the BCD time bus and any consumer that needs binary arithmetic, such as a score averager or a programmable down-count preset. It is the decode direction of the BCD counting and display path and uses a start/done handshake.

---
 rtl/bcd_to_binary_pkg.sv | 23 ++
 rtl/bcd_to_binary_if.sv | 27 ++
 rtl/bcd_digit_adjust.sv | 15 +
 rtl/bcd_to_binary.sv | 114 +++++++++++
 tb/tb_bcd_to_binary.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/bcd_to_binary_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
// Holds the FSM state encoding, default sizes and the counter-width helper.
package bcd_to_binary_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int DIGITS_DEF = 6;
    localparam int BIN_W_DEF  = 20;

    function automatic int clog2_f(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/bcd_to_binary_if.sv
// Start/done request bus between a BCD time source and the binary converter.
// The master drives the request and the slave returns status and result.
interface bcd_to_binary_if
    import bcd_to_binary_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF,
    parameter int BIN_W  = BIN_W_DEF
);

    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [BIN_W-1:0]      bin_out;

    modport master (
        output start, bcd_in,
        input  busy, done, err, bin_out
    );

    modport slave (
        input  start, bcd_in,
        output busy, done, err, bin_out
    );

endinterface

// File: rtl/bcd_digit_adjust.sv
// One BCD digit step of reverse double-dabble: digits of 8 or more lose 3.
// Purely combinational; inputs in that range are 8..15 so there is no underflow.
module bcd_digit_adjust (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    always_comb begin
        digit_out = digit_in;
        if (digit_in[3]) begin
            digit_out = digit_in - 4'd3;
        end
    end

endmodule

// File: rtl/bcd_to_binary.sv
// Reverse double-dabble BCD-to-binary converter, one shift per clock.
// Result is ready BIN_W+1 edges after the accept edge; new starts are ignored while busy.
module bcd_to_binary
    import bcd_to_binary_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF,
    parameter int BIN_W  = BIN_W_DEF
) (
    input  logic                 clock50M,
    input  logic                 reset_n,
    bcd_to_binary_if.slave       bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = clog2_f(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    state_e               state_q, state_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic [BIN_W-1:0]     bin_q, bin_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIN_W-1:0]     bin_out_q, bin_out_d;
    logic                 err_q, err_d;

    logic [BCD_W+BIN_W-1:0] shifted;
    logic [BCD_W-1:0]       bcd_adj;
    logic                   bcd_in_ok;

    assign shifted = {bcd_q, bin_q} >> 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_in  (shifted[BIN_W + 4*g +: 4]),
            .digit_out (bcd_adj[4*g +: 4])
        );
    end

    always_comb begin
        bcd_in_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.bcd_in[4*i +: 4] > 4'd9) begin
                bcd_in_ok = 1'b0;
            end
        end
    end

    always_ff @(posedge clock50M or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            bcd_q     <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            bin_out_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            bin_q     <= bin_d;
            cnt_q     <= cnt_d;
            bin_out_q <= bin_out_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        bin_d     = bin_q;
        cnt_d     = cnt_q;
        bin_out_d = bin_out_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bcd_in_ok) begin
                        bcd_d   = bus.bcd_in;
                        bin_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_SHIFT;
                    end else begin
                        // Malformed input skips the datapath and reports straight away.
                        err_d     = 1'b1;
                        bin_out_d = '0;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                bcd_d = bcd_adj;
                bin_d = shifted[BIN_W-1:0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    bin_out_d = shifted[BIN_W-1:0];
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.busy    = (state_q == ST_SHIFT);
        bus.done    = (state_q == ST_DONE);
        bus.err     = err_q;
        bus.bin_out = bin_out_q;
    end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Scoreboard bench for bcd_to_binary: expected results queued at request, checked on done.
module tb_bcd_to_binary;

    localparam int DIGITS = 6;
    localparam int BIN_W  = 20;

    typedef struct packed {
        logic [BIN_W-1:0] bin;
        logic             err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    int   n_done;
    logic [BIN_W-1:0] last_bin;
    exp_t exp_q[$];

    bcd_to_binary_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

    bcd_to_binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clock50M (clk),
        .reset_n  (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [23:0] v);
        exp_t r;
        logic [3:0] d;
        r.bin = '0;
        r.err = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = v[4*i +: 4];
            if (d > 4'd9) r.err = 1'b1;
            r.bin = r.bin * 10 + BIN_W'(d);
        end
        if (r.err) r.bin = '0;
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("bin_out", 32'(bus.bin_out), 32'(e.bin));
                chk("err", 32'(bus.err), 32'(e.err));
                chk("busy_at_done", 32'(bus.busy), 32'd0);
                last_bin = bus.bin_out;
            end
        end
    end

    // Drives one request and returns edges until done (accept edge counts as 1) and busy cycles.
    task automatic do_conv(input logic [23:0] v, output int lat, output int busy_n);
        bit seen;
        bit first;
        bus.start  = 1'b1;
        bus.bcd_in = v;
        exp_q.push_back(model(v));
        lat    = 0;
        busy_n = 0;
        seen   = 1'b0;
        first  = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            lat++;
            if (bus.busy) busy_n++;
            if (bus.done) seen = 1'b1;
            if (first && !bus.done) chk("bin_out_hold", 32'(bus.bin_out), 32'(last_bin));
            first = 1'b0;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int busy_n;
        int done_before;
        n_chk      = 0;
        n_pass     = 0;
        n_done     = 0;
        last_bin   = '0;
        bus.start  = 1'b0;
        bus.bcd_in = '0;
        rst_n      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_bin", 32'(bus.bin_out), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_conv(24'h000000, lat, busy_n);
        chk("lat_zero", 32'(lat), 32'd21);

        do_conv(24'h000734, lat, busy_n);
        chk("busy_len_734", 32'(busy_n), 32'd20);
        chk("last_734", 32'(last_bin), 32'h002DE);

        do_conv(24'h999999, lat, busy_n);
        chk("last_999999", 32'(last_bin), 32'hF423F);

        do_conv(24'h0A0000, lat, busy_n);
        chk("err_lat", 32'(lat), 32'd1);
        chk("err_busy", 32'(busy_n), 32'd0);

        // Request arriving mid-conversion must be dropped.
        bus.start  = 1'b1;
        bus.bcd_in = 24'h000250;
        exp_q.push_back(model(24'h000250));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("busy_mid", 32'(bus.busy), 32'd1);
        bus.start  = 1'b1;
        bus.bcd_in = 24'h000001;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        chk("ignored_q_empty", 32'(exp_q.size()), 32'd0);
        chk("last_250", 32'(last_bin), 32'd250);
        do_conv(24'h000001, lat, busy_n);
        chk("last_1", 32'(last_bin), 32'd1);

        // Reset in the middle of a conversion.
        bus.start  = 1'b1;
        bus.bcd_in = 24'h123456;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        chk("busy_pre_rst", 32'(bus.busy), 32'd1);
        done_before = n_done;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_err", 32'(bus.err), 32'd0);
        chk("arst_bin", 32'(bus.bin_out), 32'd0);
        last_bin = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) begin
            @(posedge clk);
            #1;
        end
        chk("no_done_after_abort", 32'(n_done - done_before), 32'd0);
        do_conv(24'h123456, lat, busy_n);
        chk("last_123456", 32'(last_bin), 32'h1E240);
        chk("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
